// File: rtl/mc_controller_if.sv
// Control bundle between the multicycle ARM controller and its datapath.
// master: the controller (drives enables/selects, receives Instr/ALUFlags).
// slave:  the datapath side.
interface mc_controller_if;
    logic [19:0] Instr;
    logic [3:0]  ALUFlags;
    logic        PCWrite;
    logic        AdrSrc;
    logic        MemWrite;
    logic        IRWrite;
    logic        RegWrite;
    logic [1:0]  ResultSrc;
    logic [1:0]  ALUSrcA;
    logic [1:0]  ALUSrcB;
    logic [1:0]  ImmSrc;
    logic [1:0]  RegSrc;
    logic [2:0]  ALUControl;
    logic        RegByte;

    modport master (
        input  Instr, ALUFlags,
        output PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite, ResultSrc,
               ALUSrcA, ALUSrcB, ImmSrc, RegSrc, ALUControl, RegByte
    );

    modport slave (
        output Instr, ALUFlags,
        input  PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite, ResultSrc,
               ALUSrcA, ALUSrcB, ImmSrc, RegSrc, ALUControl, RegByte
    );
endinterface

// File: rtl/mc_controller.sv
// Multicycle ARM controller: instruction sequencing FSM, NZCV flags and
// condition check. Optional retire counter enabled by MC_RETIRE_CNT_EN.
//
// state  | meaning
// -------+-------------------------------------------------------------
// FETCH  | read instruction at PC; IR/PC update on the last wait cycle
// DECODE | read register file, precompute PC+8
// MEMADR | compute load/store address (base +/- offset)
// MEMRD  | read data memory at ALUOut
// MEMWB  | write loaded data to Rd
// MEMWR  | write data memory at ALUOut
// EXECR  | data processing, register operand
// EXECI  | data processing, immediate operand; flags update here
// ALUWB  | write ALU result to Rd
// BRANCH | PC <= PC+8+offset
//
// Instr carries Instr[31:12]: [19:16]=Cond, [15:14]=Op, [13:8]=Funct,
// [10]=B (byte), [7:4]=Rn, [3:0]=Rd.
module mc_controller #(
    parameter int         FETCH_WAIT  = 0,
    parameter logic [3:0] RESET_FLAGS = 4'b0000
`ifdef MC_RETIRE_CNT_EN
    ,
    parameter int         CNT_W       = 32
`endif
) (
    input  logic               clk,
    input  logic               reset,
    mc_controller_if.master    bus
`ifdef MC_RETIRE_CNT_EN
    ,
    output logic [CNT_W-1:0]   RetireCnt
`endif
);
    typedef enum logic [3:0] {
        FETCH, DECODE, MEMADR, MEMRD, MEMWB, MEMWR, EXECR, EXECI, ALUWB, BRANCH
    } state_t;

    localparam logic [3:0] WAIT_LAST = 4'(FETCH_WAIT);

    state_t     state, state_nxt;
    logic [3:0] wait_cnt;
    logic [3:0] flags;
    logic       wait_done;
    logic       cond_ex;
    logic       cmd_valid;
    logic       cmd_arith;
    logic [2:0] dp_alu;

    logic [3:0] cond;
    logic [1:0] op;
    logic [5:0] funct;
    logic [3:0] rd;
    logic       unused_rn;

    assign cond      = bus.Instr[19:16];
    assign op        = bus.Instr[15:14];
    assign funct     = bus.Instr[13:8];
    assign rd        = bus.Instr[3:0];
    assign unused_rn = ^bus.Instr[7:4];
    assign wait_done = (wait_cnt == WAIT_LAST);

    // condition check against the registered flags {N,Z,C,V}
    always_comb begin
        cond_ex = 1'b0;
        case (cond)
            4'h0: cond_ex = flags[2];
            4'h1: cond_ex = !flags[2];
            4'h2: cond_ex = flags[1];
            4'h3: cond_ex = !flags[1];
            4'h4: cond_ex = flags[3];
            4'h5: cond_ex = !flags[3];
            4'h6: cond_ex = flags[0];
            4'h7: cond_ex = !flags[0];
            4'h8: cond_ex = flags[1] && !flags[2];
            4'h9: cond_ex = !flags[1] || flags[2];
            4'hA: cond_ex = (flags[3] == flags[0]);
            4'hB: cond_ex = (flags[3] != flags[0]);
            4'hC: cond_ex = !flags[2] && (flags[3] == flags[0]);
            4'hD: cond_ex = flags[2] || (flags[3] != flags[0]);
            4'hE: cond_ex = 1'b1;
            default: cond_ex = 1'b0;
        endcase
    end

    // data-processing command decode; unsupported commands fall back to ADD
    always_comb begin
        dp_alu    = 3'b000;
        cmd_valid = 1'b1;
        case (funct[4:1])
            4'b0100: dp_alu = 3'b000;
            4'b0010: dp_alu = 3'b001;
            4'b0000: dp_alu = 3'b010;
            4'b1100: dp_alu = 3'b011;
            default: cmd_valid = 1'b0;
        endcase
        cmd_arith = (dp_alu == 3'b000) || (dp_alu == 3'b001);
    end

    // state register and fetch wait counter
    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= FETCH;
            wait_cnt <= 4'd0;
        end else begin
            state    <= state_nxt;
            wait_cnt <= (state == FETCH && !wait_done) ? wait_cnt + 4'd1 : 4'd0;
        end
    end

    // NZCV register; logical ops leave C and V untouched
    always_ff @(posedge clk) begin
        if (reset) begin
            flags <= RESET_FLAGS;
        end else if ((state == EXECR || state == EXECI) && cond_ex && funct[0] && cmd_valid) begin
            if (cmd_arith) flags <= bus.ALUFlags;
            else           flags[3:2] <= bus.ALUFlags[3:2];
        end
    end

    // next-state decode
    always_comb begin
        state_nxt = FETCH;
        case (state)
            FETCH:  state_nxt = wait_done ? DECODE : FETCH;
            DECODE: begin
                case (op)
                    2'b01:   state_nxt = MEMADR;
                    2'b00:   state_nxt = funct[5] ? EXECI : EXECR;
                    2'b10:   state_nxt = BRANCH;
                    default: state_nxt = FETCH;
                endcase
            end
            MEMADR: state_nxt = funct[0] ? MEMRD : MEMWR;
            MEMRD:  state_nxt = MEMWB;
            EXECR:  state_nxt = ALUWB;
            EXECI:  state_nxt = ALUWB;
            default: state_nxt = FETCH;
        endcase
    end

    // Moore outputs per state; write enables gated by CondEx and forced low in reset
    always_comb begin
        bus.PCWrite    = 1'b0;
        bus.AdrSrc     = 1'b0;
        bus.MemWrite   = 1'b0;
        bus.IRWrite    = 1'b0;
        bus.RegWrite   = 1'b0;
        bus.ResultSrc  = 2'b00;
        bus.ALUSrcA    = 2'b00;
        bus.ALUSrcB    = 2'b00;
        bus.ALUControl = 3'b000;
        bus.ImmSrc     = op;
        bus.RegSrc     = {op == 2'b01, op == 2'b10};
        bus.RegByte    = (op == 2'b01) && bus.Instr[10];
        case (state)
            FETCH: begin
                bus.ALUSrcA   = 2'b01;
                bus.ALUSrcB   = 2'b10;
                bus.ResultSrc = 2'b10;
                bus.IRWrite   = wait_done;
                bus.PCWrite   = wait_done;
            end
            DECODE: begin
                bus.ALUSrcA   = 2'b01;
                bus.ALUSrcB   = 2'b10;
                bus.ResultSrc = 2'b10;
            end
            MEMADR: begin
                bus.ALUSrcB    = 2'b01;
                bus.ALUControl = funct[3] ? 3'b000 : 3'b001;
            end
            MEMRD: bus.AdrSrc = 1'b1;
            MEMWB: begin
                bus.ResultSrc = 2'b01;
                bus.RegWrite  = cond_ex;
                bus.PCWrite   = cond_ex && (rd == 4'hF);
            end
            MEMWR: begin
                bus.AdrSrc   = 1'b1;
                bus.MemWrite = cond_ex;
            end
            EXECR: bus.ALUControl = dp_alu;
            EXECI: begin
                bus.ALUSrcB    = 2'b01;
                bus.ALUControl = dp_alu;
            end
            ALUWB: begin
                bus.RegWrite = cond_ex && cmd_valid;
                bus.PCWrite  = cond_ex && cmd_valid && (rd == 4'hF);
            end
            BRANCH: begin
                bus.ALUSrcA   = 2'b10;
                bus.ALUSrcB   = 2'b01;
                bus.ResultSrc = 2'b10;
                bus.PCWrite   = cond_ex;
            end
            default: ;
        endcase
        if (reset) begin
            bus.PCWrite  = 1'b0;
            bus.IRWrite  = 1'b0;
            bus.RegWrite = 1'b0;
            bus.MemWrite = 1'b0;
        end
    end

`ifdef MC_RETIRE_CNT_EN
    // count every return to FETCH, i.e. every completed instruction
    always_ff @(posedge clk) begin
        if (reset)
            RetireCnt <= '0;
        else if (state != FETCH && state_nxt == FETCH)
            RetireCnt <= RetireCnt + 1'b1;
    end
`endif
endmodule

// File: tb/tb_mc_controller.sv
// Self-checking bench for mc_controller: per-cycle vector table on a
// FETCH_WAIT=0 instance, wait-state sequence on a FETCH_WAIT=3 instance,
// retire counter checks when MC_RETIRE_CNT_EN is defined.
module tb_mc_controller;
    logic        clk = 1'b0;
    logic        reset;
    logic [19:0] instr;
    logic [3:0]  aflags;

    always #5 clk = ~clk;

    mc_controller_if b0 ();
    mc_controller_if b3 ();
    assign b0.Instr    = instr;
    assign b0.ALUFlags = aflags;
    assign b3.Instr    = instr;
    assign b3.ALUFlags = aflags;

`ifdef MC_RETIRE_CNT_EN
    logic [31:0] cnt0;
    logic [31:0] cnt3;
    logic [3:0]  cntc;
    mc_controller_if bc ();
    assign bc.Instr    = instr;
    assign bc.ALUFlags = aflags;
    mc_controller #(.FETCH_WAIT(0)) dut0 (.clk(clk), .reset(reset), .bus(b0), .RetireCnt(cnt0));
    mc_controller #(.FETCH_WAIT(3)) dut3 (.clk(clk), .reset(reset), .bus(b3), .RetireCnt(cnt3));
    mc_controller #(.FETCH_WAIT(0), .CNT_W(4)) dutc (.clk(clk), .reset(reset), .bus(bc), .RetireCnt(cntc));
`else
    mc_controller #(.FETCH_WAIT(0)) dut0 (.clk(clk), .reset(reset), .bus(b0));
    mc_controller #(.FETCH_WAIT(3)) dut3 (.clk(clk), .reset(reset), .bus(b3));
`endif

    typedef struct {
        string       name;
        bit          rst;
        logic [19:0] ins;
        logic [3:0]  af;
        logic [13:0] exp;
        logic [13:0] msk;
    } vec_t;

    typedef struct {
        string       name;
        logic [13:0] exp;
        logic [13:0] msk;
        int          which;
        logic [19:0] ins;
    } sb_t;

    vec_t vecs[$];
    sb_t  sbq[$];
    int   n_vec = 0;
    int   n_err = 0;

    localparam logic [13:0] ALL = 14'h3FFF;
    localparam logic [13:0] EN  = 14'b10111_00_00_00_000;

    localparam logic [19:0] ADDS = 20'hE2921, SUBS = 20'hE2521, EORS = 20'hE0321;
    localparam logic [19:0] ANDS = 20'hE0121, BEQ = 20'h0A000, BNE = 20'h1A000;
    localparam logic [19:0] BVS = 20'h6A000, BMI = 20'h4A000, BLT = 20'hBA000;
    localparam logic [19:0] BNV = 20'hFA000, LDR = 20'hE5143, STR = 20'hE5043;
    localparam logic [19:0] LDRPC = 20'hE514F, LDRB = 20'hE5543, OP11 = 20'hEC000;

    // {PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite, ResultSrc, ALUSrcA, ALUSrcB, ALUControl}
    function automatic logic [13:0] ex(bit pcw, bit adr, bit mw, bit irw, bit rw,
                                       logic [1:0] rs, logic [1:0] sa, logic [1:0] sb,
                                       logic [2:0] ac);
        return {pcw, adr, mw, irw, rw, rs, sa, sb, ac};
    endfunction

    function automatic logic [13:0] f_go();           return ex(1,0,0,1,0,2'b10,2'b01,2'b10,3'b000); endfunction
    function automatic logic [13:0] f_stall();        return ex(0,0,0,0,0,2'b10,2'b01,2'b10,3'b000); endfunction
    function automatic logic [13:0] dec();            return ex(0,0,0,0,0,2'b10,2'b01,2'b10,3'b000); endfunction
    function automatic logic [13:0] exi(logic [2:0] a); return ex(0,0,0,0,0,2'b00,2'b00,2'b01,a); endfunction
    function automatic logic [13:0] exr(logic [2:0] a); return ex(0,0,0,0,0,2'b00,2'b00,2'b00,a); endfunction
    function automatic logic [13:0] awb(bit rw, bit p); return ex(p,0,0,0,rw,2'b00,2'b00,2'b00,3'b000); endfunction
    function automatic logic [13:0] br(bit p);        return ex(p,0,0,0,0,2'b10,2'b10,2'b01,3'b000); endfunction
    function automatic logic [13:0] madr(logic [2:0] a); return ex(0,0,0,0,0,2'b00,2'b00,2'b01,a); endfunction
    function automatic logic [13:0] mrd();            return ex(0,1,0,0,0,2'b00,2'b00,2'b00,3'b000); endfunction
    function automatic logic [13:0] mwb(bit rw, bit p); return ex(p,0,0,0,rw,2'b01,2'b00,2'b00,3'b000); endfunction
    function automatic logic [13:0] mwr(bit m);       return ex(0,1,m,0,0,2'b00,2'b00,2'b00,3'b000); endfunction

    function automatic logic [13:0] act(int which);
        if (which == 0)
            return {b0.PCWrite, b0.AdrSrc, b0.MemWrite, b0.IRWrite, b0.RegWrite,
                    b0.ResultSrc, b0.ALUSrcA, b0.ALUSrcB, b0.ALUControl};
        return {b3.PCWrite, b3.AdrSrc, b3.MemWrite, b3.IRWrite, b3.RegWrite,
                b3.ResultSrc, b3.ALUSrcA, b3.ALUSrcB, b3.ALUControl};
    endfunction

    function automatic void add(string nm, bit r, logic [19:0] in, logic [3:0] af,
                                logic [13:0] e, logic [13:0] m);
        vecs.push_back('{nm, r, in, af, e, m});
    endfunction

    // pop the oldest expectation and compare against the selected instance
    task automatic check();
        sb_t         s;
        logic [13:0] a;
        logic [4:0]  dec_exp;
        logic [4:0]  dec_act;
        s = sbq.pop_front();
        a = act(s.which);
        n_vec++;
        if ((a & s.msk) !== (s.exp & s.msk)) begin
            n_err++;
            $display("FAIL %s: got %b want %b (mask %b)", s.name, a, s.exp, s.msk);
        end
        if (s.which == 0) begin
            dec_exp = {s.ins[15:14], s.ins[15:14] == 2'b01, s.ins[15:14] == 2'b10,
                       (s.ins[15:14] == 2'b01) && s.ins[10]};
            dec_act = {b0.ImmSrc, b0.RegSrc, b0.RegByte};
            n_vec++;
            if (dec_act !== dec_exp) begin
                n_err++;
                $display("FAIL %s/decode: got %b want %b", s.name, dec_act, dec_exp);
            end
        end
    endtask

    task automatic apply(string nm, bit r, logic [19:0] in, logic [3:0] af,
                         logic [13:0] e, logic [13:0] m, int which);
        @(negedge clk);
        reset  = r;
        instr  = in;
        aflags = af;
        sbq.push_back('{nm, e, m, which, in});
        #1;
        check();
    endtask

    task automatic drive(logic [19:0] in, int cycles);
        for (int c = 0; c < cycles; c++) begin
            @(negedge clk);
            reset  = 1'b0;
            instr  = in;
            aflags = 4'b0000;
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        reset  = 1'b1;
        instr  = OP11;
        aflags = 4'b0000;

        for (int i = 0; i < 3; i++) add("reset", 1, OP11, 4'h0, 14'd0, EN);
        add("first_fetch", 0, ADDS, 4'h0, f_go(), ALL);
        add("adds_dec",    0, ADDS, 4'h0, dec(), ALL);
        add("adds_exec",   0, ADDS, 4'h0, exi(3'b000), ALL);
        add("adds_wb",     0, ADDS, 4'h0, awb(1,0), ALL);
        add("bne_f",   0, BNE, 4'h0, f_go(), ALL);
        add("bne_d",   0, BNE, 4'h0, dec(), ALL);
        add("bne_z0",  0, BNE, 4'h0, br(1), ALL);
        add("subs_f",  0, SUBS, 4'h6, f_go(), ALL);
        add("subs_d",  0, SUBS, 4'h6, dec(), ALL);
        add("subs_ex", 0, SUBS, 4'h6, exi(3'b001), ALL);
        add("subs_wb", 0, SUBS, 4'h6, awb(1,0), ALL);
        add("beq_f",   0, BEQ, 4'h0, f_go(), ALL);
        add("beq_d",   0, BEQ, 4'h0, dec(), ALL);
        add("beq_z1",  0, BEQ, 4'h0, br(1), ALL);
        add("eors_f",  0, EORS, 4'h0, f_go(), ALL);
        add("eors_d",  0, EORS, 4'h0, dec(), ALL);
        add("eors_ex", 0, EORS, 4'h0, exr(3'b000), ALL);
        add("eors_wb", 0, EORS, 4'h0, awb(0,0), ALL);
        add("beq2_f",  0, BEQ, 4'h0, f_go(), ALL);
        add("beq2_d",  0, BEQ, 4'h0, dec(), ALL);
        add("beq_kept",0, BEQ, 4'h0, br(1), ALL);
        add("subs2_f", 0, SUBS, 4'h0, f_go(), ALL);
        add("subs2_d", 0, SUBS, 4'h0, dec(), ALL);
        add("subs2_ex",0, SUBS, 4'h0, exi(3'b001), ALL);
        add("subs2_wb",0, SUBS, 4'h0, awb(1,0), ALL);
        add("beq3_f",  0, BEQ, 4'h0, f_go(), ALL);
        add("beq3_d",  0, BEQ, 4'h0, dec(), ALL);
        add("beq_z0",  0, BEQ, 4'h0, br(0), ALL);
        add("ldr_f",   0, LDR, 4'h0, f_go(), ALL);
        add("ldr_d",   0, LDR, 4'h0, dec(), ALL);
        add("ldr_adr", 0, LDR, 4'h0, madr(3'b001), ALL);
        add("ldr_rd",  0, LDR, 4'h0, mrd(), ALL);
        add("ldr_wb",  0, LDR, 4'h0, mwb(1,0), ALL);
        add("str_f",   0, STR, 4'h0, f_go(), ALL);
        add("str_d",   0, STR, 4'h0, dec(), ALL);
        add("str_adr", 0, STR, 4'h0, madr(3'b001), ALL);
        add("str_wr",  0, STR, 4'h0, mwr(1), ALL);
        add("ldrpc_f", 0, LDRPC, 4'h0, f_go(), ALL);
        add("ldrpc_d", 0, LDRPC, 4'h0, dec(), ALL);
        add("ldrpc_a", 0, LDRPC, 4'h0, madr(3'b001), ALL);
        add("ldrpc_r", 0, LDRPC, 4'h0, mrd(), ALL);
        add("ldrpc_wb",0, LDRPC, 4'h0, mwb(1,1), ALL);
        add("ldrb_f",  0, LDRB, 4'h0, f_go(), ALL);
        add("ldrb_d",  0, LDRB, 4'h0, dec(), ALL);
        add("ldrb_a",  0, LDRB, 4'h0, madr(3'b001), ALL);
        add("ldrb_r",  0, LDRB, 4'h0, mrd(), ALL);
        add("ldrb_wb", 0, LDRB, 4'h0, mwb(1,0), ALL);
        add("op11_f",  0, OP11, 4'h0, f_go(), ALL);
        add("op11_d",  0, OP11, 4'h0, dec(), ALL);
        add("op11_ret",0, ADDS, 4'h0, f_go(), ALL);
        add("adds3_d", 0, ADDS, 4'h0, dec(), ALL);
        add("adds3_ex",0, ADDS, 4'h3, exi(3'b000), ALL);
        add("adds3_wb",0, ADDS, 4'h3, awb(1,0), ALL);
        add("ands_f",  0, ANDS, 4'hC, f_go(), ALL);
        add("ands_d",  0, ANDS, 4'hC, dec(), ALL);
        add("ands_ex", 0, ANDS, 4'hC, exr(3'b010), ALL);
        add("ands_wb", 0, ANDS, 4'hC, awb(1,0), ALL);
        add("bvs_f",   0, BVS, 4'h0, f_go(), ALL);
        add("bvs_d",   0, BVS, 4'h0, dec(), ALL);
        add("bvs_held",0, BVS, 4'h0, br(1), ALL);
        add("bmi_f",   0, BMI, 4'h0, f_go(), ALL);
        add("bmi_d",   0, BMI, 4'h0, dec(), ALL);
        add("bmi_n1",  0, BMI, 4'h0, br(1), ALL);
        add("blt_f",   0, BLT, 4'h0, f_go(), ALL);
        add("blt_d",   0, BLT, 4'h0, dec(), ALL);
        add("blt_nv",  0, BLT, 4'h0, br(0), ALL);
        add("bnv_f",   0, BNV, 4'h0, f_go(), ALL);
        add("bnv_d",   0, BNV, 4'h0, dec(), ALL);
        add("bnv_1111",0, BNV, 4'h0, br(0), ALL);
        add("rstw_f",  0, STR, 4'h0, f_go(), ALL);
        add("rstw_d",  0, STR, 4'h0, dec(), ALL);
        add("rstw_a",  0, STR, 4'h0, madr(3'b001), ALL);
        add("rst_in_memwr", 1, STR, 4'h0, 14'd0, EN);
        add("after_rst",    0, OP11, 4'h0, f_go(), ALL);
        add("after_rst_d",  0, OP11, 4'h0, dec(), ALL);

        foreach (vecs[i])
            apply(vecs[i].name, vecs[i].rst, vecs[i].ins, vecs[i].af,
                  vecs[i].exp, vecs[i].msk, 0);

        // wait-state instance: FETCH held four cycles, IR/PC written only in the last
        apply("w3_reset", 1, ADDS, 4'h0, 14'd0, EN, 1);
        for (int i = 0; i < 3; i++) apply("w3_stall", 0, ADDS, 4'h0, f_stall(), ALL, 1);
        apply("w3_fetch", 0, ADDS, 4'h0, f_go(), ALL, 1);
        apply("w3_dec",   0, ADDS, 4'h0, dec(), ALL, 1);
        apply("w3_exec",  0, ADDS, 4'h0, exi(3'b000), ALL, 1);
        apply("w3_wb",    0, ADDS, 4'h0, awb(1,0), ALL, 1);
        apply("w3_refetch", 0, OP11, 4'h0, f_stall(), ALL, 1);

`ifdef MC_RETIRE_CNT_EN
        @(negedge clk);
        reset = 1'b1;
        drive(ADDS, 4); drive(BNE, 3); drive(SUBS, 4); drive(BEQ, 3); drive(LDR, 5);
        drive(STR, 4);  drive(OP11, 2); drive(ANDS, 4); drive(EORS, 4); drive(BNV, 3);
        @(posedge clk);
        #1;
        n_vec++;
        if (cnt0 !== 32'd10) begin
            n_err++;
            $display("FAIL retire10: got %0d want 10", cnt0);
        end
        n_vec++;
        if (cntc !== 4'd10) begin
            n_err++;
            $display("FAIL retire10_w4: got %0d want 10", cntc);
        end
        for (int i = 0; i < 7; i++) drive(OP11, 2);
        @(posedge clk);
        #1;
        n_vec++;
        if (cntc !== 4'd1) begin
            n_err++;
            $display("FAIL retire17_wrap: got %0d want 1", cntc);
        end
        n_vec++;
        if (cnt0 !== 32'd17) begin
            n_err++;
            $display("FAIL retire17: got %0d want 17", cnt0);
        end
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
